halfband_decim_sym: RTL

- Receive-side 2:1 halfband decimator; the counterpart of the transmit-side symmetric 15-tap halfband interpolator.
- Accepts one 1s17 sample per sys_clk2_en and produces one 1s17 sample per sam_clk_en.
- Uses the same coefficient set, with the symmetric pre-add.
- One time-shared 18x18 multiplier does a 4-cycle MAC over the non-zero taps. The centre tap is a shift, so it needs no multiplier.

---
 rtl/halfband_decim_sym_pkg.sv | 39 +++
 rtl/halfband_mac_seq.sv | 105 ++++++++++
 rtl/halfband_decim_sym.sv | 51 +++++
 3 files changed

// File: rtl/halfband_decim_sym_pkg.sv
// Shared constants for the 15-tap symmetric halfband pair (TX interpolator / RX decimator):
// sample format, coefficient set and the MAC sequencer state encoding.
package halfband_decim_sym_pkg;

  localparam int WIDTH  = 18;  // 1s17 samples and coefficients
  localparam int LENGTH = 15;  // odd halfband length
  localparam int NTAPS  = 4;   // non-zero off-centre coefficient pairs
  localparam int ACCW   = 20;  // accumulator width

  // Product bits [2*WIDTH-3:PROD_LSB] carry the 1s17-scaled tap contribution.
  localparam int PROD_LSB = WIDTH - 2;

  localparam logic signed [WIDTH-1:0] HB_H0 = -18'sd87;
  localparam logic signed [WIDTH-1:0] HB_H1 = 18'sd819;
  localparam logic signed [WIDTH-1:0] HB_H2 = -18'sd3981;
  localparam logic signed [WIDTH-1:0] HB_H3 = 18'sd19634;
  localparam logic signed [WIDTH-1:0] HB_HC = 18'sd32768;

  // The centre coefficient is a power of two at product scale, so it reduces to a shift.
  localparam int CENTRE_SHIFT = $clog2((2 ** PROD_LSB) / int'(HB_HC));

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MAC0 = 3'd1,
    ST_MAC1 = 3'd2,
    ST_MAC2 = 3'd3,
    ST_MAC3 = 3'd4
  } hb_state_t;

  function automatic logic signed [WIDTH-1:0] hb_coef(input logic [1:0] k);
    case (k)
      2'd0:    return HB_H0;
      2'd1:    return HB_H1;
      2'd2:    return HB_H2;
      default: return HB_H3;
    endcase
  endfunction

endpackage

// File: rtl/halfband_mac_seq.sv
// Time-shared MAC for the halfband decimator: one 18x18 multiplier walks the four
// pre-added tap pairs after a centre-tap seeded accumulator load.
module halfband_mac_seq
  import halfband_decim_sym_pkg::*;
(
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_load_req,
  input  logic [NTAPS-1:0][WIDTH-1:0]   i_pre,
  input  logic signed [WIDTH-1:0]       i_centre,
  output logic signed [WIDTH-1:0]       o_y,
  output logic                          o_y_valid,
  output logic                          o_overrun,
  output hb_state_t                     o_state
);

  hb_state_t                    r_state;
  logic [NTAPS-1:0][WIDTH-1:0]  r_w;
  logic signed [ACCW-1:0]       r_acc;
  logic signed [WIDTH-1:0]      r_y;
  logic                         r_y_valid;
  logic                         r_overrun;

  logic [1:0]                   w_tap_sel;
  logic signed [WIDTH-1:0]      w_coef;
  logic signed [WIDTH-1:0]      w_data;
  logic signed [2*WIDTH-1:0]    w_prod;
  logic signed [ACCW-1:0]       w_term;
  logic signed [ACCW-1:0]       w_sum;
  logic signed [ACCW-1:0]       w_centre_ext;
  logic                         w_load;

  always_comb begin
    w_tap_sel = 2'd0;
    case (r_state)
      ST_MAC1: w_tap_sel = 2'd1;
      ST_MAC2: w_tap_sel = 2'd2;
      ST_MAC3: w_tap_sel = 2'd3;
      default: w_tap_sel = 2'd0;
    endcase
  end

  assign w_coef = hb_coef(w_tap_sel);
  assign w_data = $signed(r_w[w_tap_sel]);
  assign w_prod = w_coef * w_data;

  // Arithmetic shift gives floor truncation; |term| < 2^16 so the narrowing cast is exact.
  assign w_term       = ACCW'(w_prod >>> PROD_LSB);
  assign w_sum        = r_acc + w_term;
  assign w_centre_ext = ACCW'(i_centre) >>> CENTRE_SHIFT;

  // A new block may start only when the MAC is free or finishing this very cycle.
  assign w_load = i_load_req && ((r_state == ST_IDLE) || (r_state == ST_MAC3));

  // o_y_valid is a one-cycle pulse with no back-pressure: o_y is valid exactly in the
  // cycle o_y_valid is high and holds its value until the next pulse.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_w       <= '0;
      r_acc     <= '0;
      r_y       <= '0;
      r_y_valid <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_y_valid <= 1'b0;
      if (w_load) begin
        r_w   <= i_pre;
        r_acc <= w_centre_ext;
      end
      case (r_state)
        ST_IDLE: begin
          if (i_load_req) r_state <= ST_MAC0;
        end
        ST_MAC0: begin
          r_acc   <= w_sum;
          r_state <= ST_MAC1;
          if (i_load_req) r_overrun <= 1'b1;
        end
        ST_MAC1: begin
          r_acc   <= w_sum;
          r_state <= ST_MAC2;
          if (i_load_req) r_overrun <= 1'b1;
        end
        ST_MAC2: begin
          r_acc   <= w_sum;
          r_state <= ST_MAC3;
          if (i_load_req) r_overrun <= 1'b1;
        end
        ST_MAC3: begin
          r_y       <= WIDTH'(w_sum);
          r_y_valid <= 1'b1;
          r_state   <= i_load_req ? ST_MAC0 : ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_y       = r_y;
  assign o_y_valid = r_y_valid;
  assign o_overrun = r_overrun;
  assign o_state   = r_state;

endmodule

// File: rtl/halfband_decim_sym.sv
// Receive-side 2:1 halfband decimator: input-rate delay line with symmetric pre-adders
// feeding a four-cycle time-shared MAC that emits one sample per output strobe.
module halfband_decim_sym
  import halfband_decim_sym_pkg::*;
(
  input  logic                     sys_clk,
  input  logic                     reset,
  input  logic                     sys_clk2_en,
  input  logic                     sam_clk_en,
  input  logic signed [WIDTH-1:0]  x_in,
  output logic signed [WIDTH-1:0]  y,
  output logic                     y_valid,
  output logic                     overrun,
  output hb_state_t                dbg_state
);

  logic [LENGTH-1:0][WIDTH-1:0]  r_x;
  logic [WIDTH-1:0]              w_x_half;
  logic [NTAPS-1:0][WIDTH-1:0]   w_pre;
  logic signed [WIDTH-1:0]       w_centre;

  // Halving on entry keeps each pair sum inside 18 bits.
  assign w_x_half = x_in >>> 1;

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_x <= '0;
    end else if (sys_clk2_en) begin
      r_x <= {r_x[LENGTH-2:0], w_x_half};
    end
  end

  for (genvar k = 0; k < NTAPS; k++) begin : g_pre
    assign w_pre[k] = r_x[2*k] + r_x[LENGTH-1-2*k];
  end

  assign w_centre = $signed(r_x[(LENGTH-1)/2]);

  halfband_mac_seq u_mac (
    .i_clk      (sys_clk),
    .i_reset    (reset),
    .i_load_req (sam_clk_en),
    .i_pre      (w_pre),
    .i_centre   (w_centre),
    .o_y        (y),
    .o_y_valid  (y_valid),
    .o_overrun  (overrun),
    .o_state    (dbg_state)
  );

endmodule
